gray_tracker: RTL and testbench

GRAY_TRACKER -- requirements
Module: gray_tracker

---
 rtl/gray_tracker.sv | 98 +++++++++
 tb/tb_gray_tracker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gray_tracker.sv
// Tracks a 3-bit Gray-coded position sequence, flags sequence violations and wraps.
// Optional build macro GRAY_TRACKER_HOLD_EN: treat a repeated code while LOCKED as legal.
module gray_tracker (
  input  logic       clk,
  input  logic       gcnt,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic [2:0] bin,
  output logic       locked,
  output logic       err,
  output logic       wrap,
  output logic [7:0] err_cnt
);

  typedef enum logic {SYNC = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] code;
  logic [2:0] prev_q, prev_d;
  logic [2:0] bin_q, bin_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic       wrap_q, wrap_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [2:0] succ;
  logic       hold_ok;
  logic       legal;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  assign code = {x, y, z};
  // Expected next code: step the previous code one position along the cycle.
  assign succ = bin2gray(gray2bin(prev_q) + 3'd1);

`ifdef GRAY_TRACKER_HOLD_EN
  assign hold_ok = (code == prev_q);
`else
  assign hold_ok = 1'b0;
`endif

  assign legal = (code == succ) || hold_ok;

  // State register
  always_ff @(posedge clk) begin
    if (gcnt) begin
      state_q   <= SYNC;
      prev_q    <= 3'b000;
      bin_q     <= 3'b000;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      bin_q     <= bin_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (code == 3'b000) state_d = LOCKED;
      LOCKED:  if (!legal) state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  // Output logic; a violating 000 drops to SYNC and needs a further 000 to re-lock.
  always_comb begin
    prev_d    = code;
    bin_d     = gray2bin(code);
    locked_d  = (state_d == LOCKED);
    err_d     = (state_q == LOCKED) && !legal;
    wrap_d    = (state_q == LOCKED) && (prev_q == 3'b100) && (code == 3'b000);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign bin     = bin_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Directed bench for gray_tracker: vector table plus a saturation sequence.
module tb_gray_tracker;

  logic       clk;
  logic       gcnt;
  logic       x, y, z;
  logic [2:0] bin;
  logic       locked, err, wrap;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef GRAY_TRACKER_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [2:0] code;
    logic [2:0] e_bin;
    logic       e_locked;
    logic       e_err;
    logic       e_wrap;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vec_q[$];
  logic [13:0] exp_q[$];

  gray_tracker dut (
    .clk(clk), .gcnt(gcnt), .x(x), .y(y), .z(z),
    .bin(bin), .locked(locked), .err(err), .wrap(wrap), .err_cnt(err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic rst, input logic [2:0] code, input logic [2:0] b,
                         input logic l, input logic e, input logic w, input logic [7:0] c);
    vec_t v;
    v.rst = rst; v.code = code; v.e_bin = b; v.e_locked = l;
    v.e_err = e; v.e_wrap = w; v.e_cnt = c;
    vec_q.push_back(v);
  endtask

  // driver: present inputs, take one rising edge, sample 1 time unit later
  task automatic apply(input logic rst, input logic [2:0] code);
    gcnt = rst;
    {x, y, z} = code;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got bin=%0d locked=%0b err=%0b wrap=%0b cnt=%0d, want bin=%0d locked=%0b err=%0b wrap=%0b cnt=%0d",
               name, idx, act[13:11], act[10], act[9], act[8], act[7:0],
               exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [13:0] pack_out();
    return {bin, locked, err, wrap, err_cnt};
  endfunction

  initial begin
    vec_t v;
    logic [13:0] e;
    logic [7:0]  c;

    gcnt = 1'b1;
    {x, y, z} = 3'b000;

    // reset and clean cycle with wrap
    add_vec(1, 3'b111, 3'd0, 0, 0, 0, 8'd0);
    add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'd0);
    add_vec(0, 3'b001, 3'd1, 1, 0, 0, 8'd0);
    add_vec(0, 3'b011, 3'd2, 1, 0, 0, 8'd0);
    add_vec(0, 3'b010, 3'd3, 1, 0, 0, 8'd0);
    add_vec(0, 3'b110, 3'd4, 1, 0, 0, 8'd0);
    add_vec(0, 3'b111, 3'd5, 1, 0, 0, 8'd0);
    add_vec(0, 3'b101, 3'd6, 1, 0, 0, 8'd0);
    add_vec(0, 3'b100, 3'd7, 1, 0, 0, 8'd0);
    add_vec(0, 3'b000, 3'd0, 1, 0, 1, 8'd0);
    // skip 011 -> 110
    add_vec(0, 3'b001, 3'd1, 1, 0, 0, 8'd0);
    add_vec(0, 3'b011, 3'd2, 1, 0, 0, 8'd0);
    add_vec(0, 3'b110, 3'd4, 0, 1, 0, 8'd1);
    add_vec(0, 3'b110, 3'd4, 0, 0, 0, 8'd1);
    // hold at 001
    add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'd1);
    add_vec(0, 3'b001, 3'd1, 1, 0, 0, 8'd1);
    add_vec(0, 3'b001, 3'd1, HOLD, !HOLD, 0, HOLD ? 8'd1 : 8'd2);
    add_vec(0, 3'b001, 3'd1, HOLD, 0, 0, HOLD ? 8'd1 : 8'd2);
    // violating 000 must not re-lock at once
    add_vec(1, 3'b111, 3'd0, 0, 0, 0, 8'd0);
    add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'd0);
    add_vec(0, 3'b001, 3'd1, 1, 0, 0, 8'd0);
    add_vec(0, 3'b000, 3'd0, 0, 1, 0, 8'd1);
    add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'd1);
    add_vec(0, 3'b011, 3'd2, 0, 1, 0, 8'd2);
    // reset mid-operation with err_cnt = 5, locked at 110
    add_vec(1, 3'b000, 3'd0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'(i));
      add_vec(0, 3'b111, 3'd5, 0, 1, 0, 8'(i + 1));
    end
    add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'd5);
    add_vec(0, 3'b001, 3'd1, 1, 0, 0, 8'd5);
    add_vec(0, 3'b011, 3'd2, 1, 0, 0, 8'd5);
    add_vec(0, 3'b010, 3'd3, 1, 0, 0, 8'd5);
    add_vec(0, 3'b110, 3'd4, 1, 0, 0, 8'd5);
    add_vec(1, 3'b111, 3'd0, 0, 0, 0, 8'd0);
    add_vec(0, 3'b000, 3'd0, 1, 0, 0, 8'd0);

    foreach (vec_q[i]) begin
      v = vec_q[i];
      exp_q.push_back({v.e_bin, v.e_locked, v.e_err, v.e_wrap, v.e_cnt});
    end

    for (int i = 0; i < vec_q.size(); i++) begin
      apply(vec_q[i].rst, vec_q[i].code);
      e = exp_q.pop_front();
      check("table", i, pack_out(), e);
    end

    // saturation: 300 lock/violate pairs
    apply(1'b1, 3'b000);
    check("sat_reset", 0, pack_out(), 14'd0);
    c = 8'd0;
    for (int i = 0; i < 300; i++) begin
      apply(1'b0, 3'b000);
      check("sat_lock", i, pack_out(), {3'd0, 1'b1, 1'b0, 1'b0, c});
      if (c != 8'hff) c = c + 8'd1;
      apply(1'b0, 3'b111);
      check("sat_err", i, pack_out(), {3'd5, 1'b0, 1'b1, 1'b0, c});
    end
    apply(1'b0, 3'b111);
    check("sat_hold", 0, pack_out(), {3'd5, 1'b0, 1'b0, 1'b0, 8'd255});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
